fifo2axis_pkt: RTL

Parametrised successor to the single-register FIFO-to-AXI-Stream adapter: a DEPTH-entry buffered bridge from an accelerator FIFO-write port to an AXI4-Stream master. It forms packets either of a programmed beat count or, in unbounded mode, terminated by a flush request. It sits between accelerator output logic and the DMA/stream interconnect. FIFO_FULL is registered-state only, with no combinational path from AXIS_TREADY.

---
 rtl/fifo2axis_pkt.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fifo2axis_pkt.sv
`default_nettype none
// =============================================================================
// Module   : fifo2axis_pkt
// Brief    : DEPTH-entry buffered bridge from an accelerator FIFO-write port to
//            an AXI4-Stream master, framing packets by beat count or by flush.
//            Define FIFO2AXIS_PKT_STATUS_EN to add the CTRL_BEATS status port.
// Revision : 1.0 - initial release
// =============================================================================
module fifo2axis_pkt #(
   parameter int DATA_WIDTH  = 64,
   parameter int DEPTH       = 4,
   parameter int LEN_WIDTH   = 16,
   parameter bit FULL_ACTIVE = 1'b0
) (
   input  logic                  ACC_CLK,
   input  logic                  ARESETN,
   input  logic                  CTRL_START,
   input  logic [LEN_WIDTH-1:0]  CTRL_LEN,
   input  logic                  CTRL_ALLOW,
   output logic                  CTRL_READY,
   output logic                  CTRL_FINISHED,
   output logic [DATA_WIDTH-1:0] AXIS_TDATA,
   output logic                  AXIS_TVALID,
   output logic                  AXIS_TLAST,
   input  logic                  AXIS_TREADY,
   output logic                  FIFO_FULL,
   input  logic [DATA_WIDTH-1:0] FIFO_DIN,
   input  logic                  FIFO_WRITE
`ifdef FIFO2AXIS_PKT_STATUS_EN
   ,
   output logic [LEN_WIDTH-1:0]  CTRL_BEATS
`endif
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
   localparam logic [c_cnt_w-1:0] c_cnt_two  = c_cnt_w'(2);
   localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [c_ptr_w-1:0]    r_wr_ptr;
   logic [c_ptr_w-1:0]    r_rd_ptr;
   logic [c_cnt_w-1:0]    r_count;
   logic [LEN_WIDTH-1:0]  r_len;
   logic                  r_unbounded;
   logic [LEN_WIDTH-1:0]  r_acc;
   logic [LEN_WIDTH-1:0]  w_acc_inc;
   logic                  w_len_done;
   logic                  w_full;
   logic                  w_wr_en;
   logic                  w_present;
   logic                  w_rd_en;
   logic                  w_start;

   // Back-pressure depends on registered state only, never on AXIS_TREADY.
   assign w_len_done = !r_unbounded && (r_acc >= r_len);
   assign w_full     = (r_state != ST_RUN) || (r_count == c_cnt_full) || w_len_done;
   assign w_wr_en    = FIFO_WRITE && !w_full;
   assign w_acc_inc  = (r_acc == '1) ? r_acc : r_acc + 1'b1;
   assign w_start    = (r_state == ST_IDLE) && CTRL_START;

   // Unbounded packets hold back the newest entry while running so the final
   // beat is still in the buffer when the flush decides it carries TLAST.
   always_comb begin
      w_present = 1'b0;
      case (r_state)
         ST_RUN:   w_present = r_unbounded ? (r_count >= c_cnt_two) : (r_count != '0);
         ST_DRAIN: w_present = (r_count != '0);
         default:  w_present = 1'b0;
      endcase
   end

   assign w_rd_en       = w_present && AXIS_TREADY;
   assign AXIS_TVALID   = w_present;
   assign AXIS_TDATA    = w_present ? r_mem[r_rd_ptr] : '0;
   assign AXIS_TLAST    = (r_state == ST_DRAIN) && (r_count == c_cnt_one);
   assign CTRL_READY    = (r_state == ST_IDLE);
   assign CTRL_FINISHED = (r_state == ST_DONE);
   assign FIFO_FULL     = FULL_ACTIVE ? w_full : !w_full;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (CTRL_START) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (CTRL_ALLOW || (w_wr_en && !r_unbounded && (w_acc_inc == r_len)))
               w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            // An empty buffer here means nothing is left to carry TLAST.
            if ((r_count == '0) || (w_rd_en && (r_count == c_cnt_one)))
               w_state_nxt = ST_DONE;
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACC_CLK) begin
      if (!ARESETN) begin
         r_state     <= ST_IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_len       <= '0;
         r_unbounded <= 1'b0;
         r_acc       <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start) begin
            r_len       <= CTRL_LEN;
            r_unbounded <= (CTRL_LEN == '0);
            r_acc       <= '0;
         end else if (w_wr_en) begin
            r_acc <= w_acc_inc;
         end
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge ACC_CLK) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= FIFO_DIN;
   end

`ifdef FIFO2AXIS_PKT_STATUS_EN
   logic [LEN_WIDTH-1:0] r_beats;

   always_ff @(posedge ACC_CLK) begin
      if (!ARESETN) begin
         r_beats <= '0;
      end else if (w_start) begin
         r_beats <= '0;
      end else if (w_rd_en && (r_beats != '1)) begin
         r_beats <= r_beats + 1'b1;
      end
   end

   assign CTRL_BEATS = r_beats;
`endif

endmodule
`default_nettype wire
